l2_sched: RTL and testbench
===========================

Name: l2_sched

Overview:
- Frame-level scheduler for the pointwise conv layer: one lyr_strt pulse per output pixel, gated on upstream data availability and layer busy.
- Counts completed pixels and waits for the downstream reader to drain.
- Issues the one-cycle frame_done pulse that all layers use as tx_done.
- Sits between the layer-1 output buffer and the layer-2 datapath.

Parameters:
- N_PIX, 144, output pixels per frame (12x12 map).
- ACK_TO, 3, max cycles from lyr_strt to lyr_bsy high before an ack timeout.
- CNT_W, 8, width of pixel counter; must satisfy 2^CNT_W > N_PIX.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- frame_start  in  1  pulse: begin a new frame
- abort  in  1  pulse: terminate the current frame
- src_vld  in  1  upstream holds data for next pixel
- src_pop  out  1  pulse: upstream advances to next pixel
- lyr_strt  out  1  pulse to layer datapath
- lyr_bsy  in  1  layer accumulating
- sink_done  in  1  level: downstream has read all pooled outputs
- frame_done  out  1  one-cycle pulse, fans out as tx_done
- pix_cnt  out  CNT_W  completed pixels in current frame
- busy  out  1  high in any state except IDLE
- err  out  1  sticky ack-timeout flag

Behaviour:
- Reset values: all outputs 0; state IDLE; ack-timer 0.
- Outputs src_pop, lyr_strt and frame_done are registered, one cycle wide.
- IDLE:
  - frame_start -> ISSUE; pix_cnt cleared the same edge.
  - err cleared on frame_start.
- ISSUE:
  - When src_vld && !lyr_bsy: assert lyr_strt for exactly one cycle and go to WAIT_ACK.
  - Otherwise stay in ISSUE.
- WAIT_ACK:
  - Ack-timer counts cycles.
  - lyr_bsy seen high -> RUN.
  - Timer reaches ACK_TO with no bsy -> set err, go to DONE (frame aborted).
- RUN: on lyr_bsy falling edge (registered previous value 1, current 0):
  - pix_cnt += 1 and src_pop pulses on the same edge.
  - pix_cnt+1 == N_PIX -> DRAIN; else -> ISSUE.
- Throughput: with src_vld held high, the next lyr_strt is issued no earlier than 1 cycle after the bsy fall.
- DRAIN: wait for sink_done high, then -> DONE.
- DONE: frame_done=1 for one cycle -> IDLE; pix_cnt holds its final value until the next frame_start.
- abort:
  - In any non-IDLE state: next cycle is DONE (frame_done pulses, so layers reset their address counters).
  - In IDLE: ignored.
  - Priority: abort > timeout > normal transitions.
- frame_start while busy: ignored, no queueing.
- src_pop never asserts in the same cycle as lyr_strt.
- pix_cnt never exceeds N_PIX; there is no wrap within a frame.
- Reset mid-frame: immediate return to IDLE with all outputs 0; no frame_done is generated.

Optional Feature:
- Macro L2_SCHED_PERF_EN.
- When defined:
  - Adds output perf_cyc [15:0].
  - Internal counter clears on frame_start and increments every cycle while busy, saturating at 16'hFFFF.
  - Counter is copied to perf_cyc on the frame_done cycle; perf_cyc holds between frames and resets to 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package cnn_pkg:
  - sched_state_t enum {IDLE, ISSUE, WAIT_ACK, RUN, DRAIN, DONE}.
  - Constants L2_N_PIX=144 and L2_ACK_TO=3.
- One sub-module is natural: l2_sched_wdog, holding the ack-timer and err sticky logic (inputs start/clear/bsy, output timeout).

Test Plan:
- Normal frame:
  - Stimulus: frame_start; src_vld=1; layer model holds bsy 10 cycles after each strt; sink_done=1.
  - Response: 144 lyr_strt pulses and 144 src_pop pulses; pix_cnt=144; exactly one frame_done; busy falls the cycle after frame_done.
- Stalled source:
  - Stimulus: src_vld=0 for 20 cycles after pixel 5.
  - Response: no lyr_strt during the stall; resumes one cycle after src_vld rises; final pix_cnt=144.
- Ack timeout:
  - Stimulus: layer model never raises bsy.
  - Response: err=1 exactly 3 cycles after lyr_strt; frame_done pulses; IDLE; err clears on the next frame_start.
- Abort:
  - Stimulus: abort at pix_cnt=37 during RUN.
  - Response: frame_done next cycle; pix_cnt holds 37; no further lyr_strt.
- Drain hold:
  - Stimulus: sink_done=0 for 50 cycles after pixel 144.
  - Response: state DRAIN, busy=1, no frame_done until sink_done=1, then one pulse.
- Perf (L2_SCHED_PERF_EN defined):
  - Stimulus: normal frame as in the first test.
  - Response: perf_cyc equals the measured frame_start-to-frame_done cycle count and is held after the frame.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN layer schedulers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cnn_pkg;

  // Layer-2 frame geometry: 12x12 output map, one lyr_strt per pixel.
  localparam int L2_N_PIX  = 144;
  // Cycles allowed between lyr_strt and lyr_bsy rising.
  localparam int L2_ACK_TO = 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT_ACK = 3'd2,
    RUN      = 3'd3,
    DRAIN    = 3'd4,
    DONE     = 3'd5
  } sched_state_t;

endpackage

// File: rtl/l2_sched_wdog.sv
// Ack watchdog: times lyr_strt -> lyr_bsy and keeps a sticky error flag.
// Latency: timeout is combinational on the ACK_TO-th armed cycle; err registers on that edge.
// Backpressure: none; bsy simply disarms the timer.
// Ports: start  - arm and zero the timer (pixel issued)
//        clear  - new frame: disarm and drop err
//        cancel - frame aborted: disarm, suppress timeout, keep err
//        bsy    - layer busy; ends the wait
//        timeout- fires for one cycle when the wait expires
//        err    - sticky timeout flag
module l2_sched_wdog #(
  parameter int ACK_TO = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic clear,
  input  logic cancel,
  input  logic bsy,
  output logic timeout,
  output logic err
);

  localparam int TW = $clog2(ACK_TO + 1);

  logic [TW-1:0] tmr;
  logic          armed;

  // Timer starts at 0 on the lyr_strt cycle, so the expiry compare is
  // against ACK_TO-1: err becomes visible exactly ACK_TO cycles after lyr_strt.
  assign timeout = armed && !bsy && !cancel && (tmr == TW'(ACK_TO - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr   <= '0;
      armed <= 1'b0;
      err   <= 1'b0;
    end else if (clear) begin
      tmr   <= '0;
      armed <= 1'b0;
      err   <= 1'b0;
    end else if (start) begin
      tmr   <= '0;
      armed <= 1'b1;
    end else if (armed) begin
      if (cancel || bsy) begin
        tmr   <= '0;
        armed <= 1'b0;
      end else if (timeout) begin
        tmr   <= '0;
        armed <= 1'b0;
        err   <= 1'b1;
      end else begin
        tmr <= tmr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2_sched.sv
// Layer-2 frame scheduler: one lyr_strt per output pixel, frame_done (tx_done) at frame end.
// Latency: lyr_strt one cycle after ISSUE sees src_vld && !lyr_bsy; src_pop one cycle after bsy falls.
// Backpressure: stalls in ISSUE on !src_vld or lyr_bsy, in DRAIN until sink_done.
// Ports: frame_start/abort pulses; src_vld/src_pop upstream buffer handshake;
//        lyr_strt/lyr_bsy layer datapath handshake; sink_done downstream drained;
//        frame_done, pix_cnt, busy, err status.
// Build option: L2_SCHED_PERF_EN adds perf_cyc[15:0], the busy-cycle count of the last frame.
module l2_sched
  import cnn_pkg::*;
#(
  parameter int N_PIX  = L2_N_PIX,
  parameter int ACK_TO = L2_ACK_TO,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             abort,
  input  logic             src_vld,
  output logic             src_pop,
  output logic             lyr_strt,
  input  logic             lyr_bsy,
  input  logic             sink_done,
  output logic             frame_done,
  output logic [CNT_W-1:0] pix_cnt,
  output logic             busy,
  output logic             err
`ifdef L2_SCHED_PERF_EN
  ,
  output logic [15:0]      perf_cyc
`endif
);

  sched_state_t state, nxt;
  logic         bsy_q;
  logic         issue, px_done;
  logic         start_ok, abort_ok, timeout;
  logic         last_pix;

  assign busy     = (state != IDLE);
  assign start_ok = (state == IDLE) && frame_start;
  // DONE already ends the frame with its own pulse; re-entering it would
  // stretch frame_done to two cycles.
  assign abort_ok = abort && (state != IDLE) && (state != DONE);
  assign last_pix = (pix_cnt == CNT_W'(N_PIX - 1));

  always_comb begin
    nxt     = state;
    issue   = 1'b0;
    px_done = 1'b0;
    case (state)
      IDLE:     if (frame_start) nxt = ISSUE;
      ISSUE:    if (src_vld && !lyr_bsy) begin
                  nxt   = WAIT_ACK;
                  issue = 1'b1;
                end
      WAIT_ACK: if (lyr_bsy)      nxt = RUN;
                else if (timeout) nxt = DONE;
      // Falling edge of bsy marks the pixel as accumulated.
      RUN:      if (bsy_q && !lyr_bsy) begin
                  px_done = 1'b1;
                  nxt     = last_pix ? DRAIN : ISSUE;
                end
      DRAIN:    if (sink_done) nxt = DONE;
      DONE:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
    if (abort_ok) begin
      nxt     = DONE;
      issue   = 1'b0;
      px_done = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bsy_q      <= 1'b0;
      lyr_strt   <= 1'b0;
      src_pop    <= 1'b0;
      frame_done <= 1'b0;
      pix_cnt    <= '0;
    end else begin
      state      <= nxt;
      bsy_q      <= lyr_bsy;
      lyr_strt   <= issue;
      src_pop    <= px_done;
      frame_done <= (nxt == DONE);
      if (start_ok)     pix_cnt <= '0;
      else if (px_done) pix_cnt <= pix_cnt + 1'b1;
    end
  end

  l2_sched_wdog #(
    .ACK_TO (ACK_TO)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (issue),
    .clear   (start_ok),
    .cancel  (abort_ok),
    .bsy     (lyr_bsy),
    .timeout (timeout),
    .err     (err)
  );

`ifdef L2_SCHED_PERF_EN
  logic [15:0] perf_cnt, perf_nxt;

  assign perf_nxt = (perf_cnt == 16'hFFFF) ? perf_cnt : perf_cnt + 16'd1;

  // Snapshot takes the incremented value so the DONE cycle is included:
  // perf_cyc equals the frame_start-to-frame_done distance in cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt <= '0;
      perf_cyc <= '0;
    end else begin
      if (start_ok)  perf_cnt <= '0;
      else if (busy) perf_cnt <= perf_nxt;
      if (frame_done) perf_cyc <= perf_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_l2_sched.sv
// Directed bench for l2_sched: normal frame, source stall, ack timeout,
// abort, drain hold and reset mid-frame, against hand-computed values.
module tb_l2_sched;

  localparam int N_PIX = 144;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       abort = 1'b0;
  logic       src_vld = 1'b0;
  logic       lyr_bsy = 1'b0;
  logic       sink_done = 1'b0;
  logic       src_pop, lyr_strt, frame_done, busy, err;
  logic [7:0] pix_cnt;
`ifdef L2_SCHED_PERF_EN
  logic [15:0] perf_cyc;
`endif

  always #5 clk = ~clk;

  l2_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .abort       (abort),
    .src_vld     (src_vld),
    .src_pop     (src_pop),
    .lyr_strt    (lyr_strt),
    .lyr_bsy     (lyr_bsy),
    .sink_done   (sink_done),
    .frame_done  (frame_done),
    .pix_cnt     (pix_cnt),
    .busy        (busy),
    .err         (err)
`ifdef L2_SCHED_PERF_EN
    ,
    .perf_cyc    (perf_cyc)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (!frame_done && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 32'(frame_done), 32'd1);
  endtask

  task automatic wait_pix(input string tag, input int val, input int budget);
    int k = 0;
    while (int'(pix_cnt) != val && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 32'(pix_cnt), val);
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Cycle index, advanced on every rising edge.
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Layer model: bsy high for 10 cycles starting the cycle after lyr_strt.
  bit lyr_en = 1'b1;
  int bsy_left = 0;
  initial forever begin
    tick();
    if (bsy_left > 0) begin
      lyr_bsy = 1'b1;
      bsy_left--;
    end else begin
      lyr_bsy = 1'b0;
    end
    if (lyr_strt && lyr_en) bsy_left = 10;
  end

  // Output monitor, sampled on the falling edge.
  int n_strt = 0, n_pop = 0, n_done = 0, n_ovl = 0, n_ovf = 0;
  int pop_cyc = -100000, min_gap = 100000;
  int err_cyc = 0, start_cyc = 0, bfall_cyc = 0;
  bit err_q = 1'b0, busy_q = 1'b0;
  initial forever begin
    @(negedge clk);
    if (lyr_strt) begin
      n_strt++;
      if (cyc - pop_cyc < min_gap) min_gap = cyc - pop_cyc;
    end
    if (src_pop) begin
      n_pop++;
      pop_cyc = cyc;
    end
    if (src_pop && lyr_strt) n_ovl++;
    if (int'(pix_cnt) > N_PIX) n_ovf++;
    if (frame_done) n_done++;
    if (err && !err_q) err_cyc = cyc;
    err_q = err;
    if (frame_start && !busy && rst_n) start_cyc = cyc;
    if (busy_q && !busy) bfall_cyc = cyc;
    busy_q = busy;
  end

  initial begin
    int s_strt, s_pop, s_done, c0, bad;

    // Reset state
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pix_cnt", 32'(pix_cnt), 32'd0);
    chk("rst_lyr_strt", 32'(lyr_strt), 32'd0);
    chk("rst_src_pop", 32'(src_pop), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
`ifdef L2_SCHED_PERF_EN
    chk("rst_perf_cyc", 32'(perf_cyc), 32'd0);
`endif
    rst_n = 1'b1;
    repeat (2) tick();

    // Abort while idle is ignored
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (3) tick();
    chk("idle_abort_busy", 32'(busy), 32'd0);
    chk("idle_abort_done", n_done, 32'd0);

    // Normal frame: pixel period 13, first strt at S+2, DONE at S+1874
    src_vld = 1'b1;
    sink_done = 1'b1;
    lyr_en = 1'b1;
    s_strt = n_strt;
    s_pop = n_pop;
    s_done = n_done;
    pulse_start();
    chk("norm_busy_on", 32'(busy), 32'd1);
    wait_done("norm_done_seen", 5000);
    c0 = cyc;
    chk("norm_start_to_done", c0 - start_cyc, 32'd1874);
    tick();
    chk("norm_busy_off", 32'(busy), 32'd0);
    repeat (5) tick();
    chk("norm_strt_cnt", n_strt - s_strt, 32'd144);
    chk("norm_pop_cnt", n_pop - s_pop, 32'd144);
    chk("norm_pix_cnt", 32'(pix_cnt), 32'd144);
    chk("norm_one_done", n_done - s_done, 32'd1);
    chk("norm_busy_fall", bfall_cyc - c0, 32'd1);
    chk("norm_min_gap", min_gap, 32'd1);
`ifdef L2_SCHED_PERF_EN
    chk("perf_cyc", 32'(perf_cyc), 32'd1874);
    repeat (20) tick();
    chk("perf_cyc_hold", 32'(perf_cyc), 32'd1874);
`endif

    // Stalled source after pixel 5
    s_strt = n_strt;
    s_pop = n_pop;
    pulse_start();
    begin
      int np = 0, k = 0;
      while (np < 5 && k < 2000) begin
        tick();
        if (src_pop) np++;
        k++;
      end
      chk("stall_reach5", np, 32'd5);
    end
    src_vld = 1'b0;
    c0 = n_strt;
    repeat (20) tick();
    chk("stall_no_strt", n_strt - c0, 32'd0);
    src_vld = 1'b1;
    tick();
    chk("stall_resume", 32'(lyr_strt), 32'd1);
    wait_done("stall_done_seen", 5000);
    repeat (2) tick();
    chk("stall_pix_cnt", 32'(pix_cnt), 32'd144);
    chk("stall_strt_cnt", n_strt - s_strt, 32'd144);
    chk("stall_pop_cnt", n_pop - s_pop, 32'd144);

    // Ack timeout: layer never acknowledges
    lyr_en = 1'b0;
    repeat (5) tick();
    s_strt = n_strt;
    s_done = n_done;
    pulse_start();
    begin
      int k = 0;
      while (!lyr_strt && k < 50) begin
        tick();
        k++;
      end
    end
    chk("to_strt_seen", 32'(lyr_strt), 32'd1);
    c0 = cyc;
    wait_done("to_done_seen", 20);
    chk("to_done_lat", cyc - c0, 32'd3);
    chk("to_err_at_done", 32'(err), 32'd1);
    repeat (3) tick();
    chk("to_err_lat", err_cyc - c0, 32'd3);
    chk("to_idle", 32'(busy), 32'd0);
    chk("to_err_sticky", 32'(err), 32'd1);
    chk("to_one_strt", n_strt - s_strt, 32'd1);
    chk("to_one_done", n_done - s_done, 32'd1);

    // Abort at pix_cnt=37 during RUN; err clears on this frame_start
    lyr_en = 1'b1;
    s_done = n_done;
    pulse_start();
    chk("err_clear", 32'(err), 32'd0);
    wait_pix("abort_reach37", 37, 1000);
    repeat (6) tick();
    abort = 1'b1;
    c0 = n_strt;
    tick();
    abort = 1'b0;
    chk("abort_done_next", 32'(frame_done), 32'd1);
    chk("abort_pix_cnt", 32'(pix_cnt), 32'd37);
    repeat (30) tick();
    chk("abort_no_strt", n_strt - c0, 32'd0);
    chk("abort_one_done", n_done - s_done, 32'd1);
    chk("abort_pix_hold", 32'(pix_cnt), 32'd37);
    chk("abort_idle", 32'(busy), 32'd0);

    // Drain hold: sink_done low for 50 cycles after pixel 144
    sink_done = 1'b0;
    repeat (15) tick();
    s_done = n_done;
    pulse_start();
    wait_pix("drain_reach144", 144, 3000);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (frame_done || !busy) bad++;
      tick();
    end
    chk("drain_hold", bad, 32'd0);
    sink_done = 1'b1;
    tick();
    chk("drain_done", 32'(frame_done), 32'd1);
    tick();
    chk("drain_done_one", 32'(frame_done), 32'd0);
    chk("drain_idle", 32'(busy), 32'd0);
    repeat (3) tick();
    chk("drain_one_done", n_done - s_done, 32'd1);

    // Reset mid-frame: straight to idle, no frame_done
    s_done = n_done;
    pulse_start();
    repeat (30) tick();
    rst_n = 1'b0;
    #2;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_pix_cnt", 32'(pix_cnt), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("midrst_no_done", n_done - s_done, 32'd0);
    chk("midrst_idle", 32'(busy), 32'd0);

    // Invariants over the whole run
    chk("pop_strt_overlap", n_ovl, 32'd0);
    chk("pix_cnt_overflow", n_ovf, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
